rr_regid_encoder_16_4: RTL and testbench



---
 rtl/rr_regid_encoder_16_4.sv | 68 ++++++
 tb/tb_rr_regid_encoder_16_4.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_regid_encoder_16_4.sv
// Round-robin 16:4 request encoder: picks one of 16 per-register request lines
// and presents its RegId/one-hot Grant on a registered valid/ready output.
module rr_regid_encoder_16_4 #(
    parameter logic [3:0] RESET_PTR = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Request,
    input  logic        Ready,
    output logic        Valid,
    output logic [3:0]  RegId,
    output logic [15:0] Grant,
    output logic        Any
);

    localparam int unsigned N = 16;
    localparam int unsigned W = 4;

    logic [W-1:0] ptr;
    logic         accept;
    logic         load_en;
    logic [W-1:0] scan_start;
    logic [W-1:0] scan_idx;
    logic [W-1:0] sel;
    logic         found;

    assign Any     = |Request;
    assign accept  = Valid & Ready;
    assign load_en = ~Valid | Ready;

    // The just-accepted index must lose priority at the same edge ptr moves to it.
    assign scan_start = accept ? W'(RegId + W'(1)) : W'(ptr + W'(1));

    // First set request at or after scan_start, wrapping 15 -> 0.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            scan_idx = W'(scan_start + W'(i));
            if (!found && Request[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Valid <= 1'b0;
            RegId <= '0;
            Grant <= '0;
            ptr   <= RESET_PTR;
        end else begin
            if (accept) begin
                ptr <= RegId;
            end
            if (load_en) begin
                Valid <= found;
                Grant <= found ? (N'(1) << sel) : '0;
                if (found) begin
                    RegId <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_regid_encoder_16_4.sv
// Bench for rr_regid_encoder_16_4: directed vector table followed by random
// traffic checked against a distance-based round-robin reference model.
module tb_rr_regid_encoder_16_4;

    logic        clk;
    logic        rst;
    logic [15:0] Request;
    logic        Ready;
    logic        Valid;
    logic [3:0]  RegId;
    logic [15:0] Grant;
    logic        Any;

    int checks = 0;
    int errors = 0;

    rr_regid_encoder_16_4 #(.RESET_PTR(4'd15)) dut (
        .clk     (clk),
        .rst     (rst),
        .Request (Request),
        .Ready   (Ready),
        .Valid   (Valid),
        .RegId   (RegId),
        .Grant   (Grant),
        .Any     (Any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rdy;
        logic        ev;
        logic [3:0]  er;
        logic [15:0] eg;
    } vec_t;

    vec_t tbl[$];

    // Reference state: what the output register and last-accepted pointer should hold.
    logic       m_valid;
    logic [3:0] m_regid;
    int         m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner is the set request closest after the base index in circular order.
    task automatic model_step(input logic r, input logic [15:0] req, input logic rdy);
        int base;
        int best;
        int bestd;
        int d;
        if (r) begin
            m_valid = 1'b0;
            m_regid = 4'd0;
            m_ptr   = 15;
        end else begin
            base = (m_valid && rdy) ? int'(m_regid) : m_ptr;
            if (m_valid && rdy) m_ptr = int'(m_regid);
            if (!m_valid || rdy) begin
                best  = -1;
                bestd = 99;
                for (int i = 0; i < 16; i++) begin
                    if (req[i]) begin
                        d = (i - base - 1 + 32) % 16;
                        if (d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
                if (best >= 0) begin
                    m_valid = 1'b1;
                    m_regid = 4'(best);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle's inputs, check Any, then sample outputs just after the edge.
    task automatic drive(input logic r, input logic [15:0] req, input logic rdy);
        rst     = r;
        Request = req;
        Ready   = rdy;
        #1;
        check("any", 32'(Any), 32'(|req));
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [15:0] req, input logic rdy,
                       input logic ev, input logic [3:0] er, input logic [15:0] eg);
        vec_t v;
        v.rst = r; v.req = req; v.rdy = rdy; v.ev = ev; v.er = er; v.eg = eg;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] rreq;
        logic        rrdy;
        logic        rrst;

        rst = 1'b1; Request = '0; Ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_regid", 32'(RegId), 32'd0);
        check("reset_grant", 32'(Grant), 32'd0);

        // idle
        add(0, 16'h0000, 1, 0, 4'd0,  16'h0000);
        add(0, 16'h0000, 1, 0, 4'd0,  16'h0000);
        add(0, 16'h0000, 1, 0, 4'd0,  16'h0000);
        // two requesters alternate at full rate
        add(0, 16'h8001, 1, 1, 4'd0,  16'h0001);
        add(0, 16'h8001, 1, 1, 4'd15, 16'h8000);
        add(0, 16'h8001, 1, 1, 4'd0,  16'h0001);
        add(0, 16'h8001, 1, 1, 4'd15, 16'h8000);
        // backpressure holds the grant
        add(1, 16'h0000, 0, 0, 4'd0,  16'h0000);
        add(0, 16'h0024, 0, 1, 4'd2,  16'h0004);
        add(0, 16'h0024, 0, 1, 4'd2,  16'h0004);
        add(0, 16'h0024, 0, 1, 4'd2,  16'h0004);
        add(0, 16'h0024, 0, 1, 4'd2,  16'h0004);
        add(0, 16'h0024, 1, 1, 4'd5,  16'h0020);
        add(0, 16'h0000, 1, 0, 4'd5,  16'h0000);
        // wrap-around after accepting 14
        add(0, 16'h4000, 1, 1, 4'd14, 16'h4000);
        add(0, 16'hC001, 1, 1, 4'd15, 16'h8000);
        add(0, 16'hC001, 1, 1, 4'd0,  16'h0001);
        add(0, 16'hC001, 1, 1, 4'd14, 16'h4000);
        add(0, 16'h0000, 1, 0, 4'd14, 16'h0000);
        // reset discards a held grant without moving ptr
        add(0, 16'h0200, 0, 1, 4'd9,  16'h0200);
        add(1, 16'h0200, 0, 0, 4'd0,  16'h0000);
        add(0, 16'h0200, 0, 1, 4'd9,  16'h0200);
        // held grant survives its request dropping
        add(1, 16'h0000, 0, 0, 4'd0,  16'h0000);
        add(0, 16'h0008, 0, 1, 4'd3,  16'h0008);
        add(0, 16'h0080, 0, 1, 4'd3,  16'h0008);
        add(0, 16'h0080, 0, 1, 4'd3,  16'h0008);
        add(0, 16'h0080, 1, 1, 4'd7,  16'h0080);
        add(0, 16'h0000, 1, 0, 4'd7,  16'h0000);
        // single requester repeats every cycle
        add(0, 16'h0010, 1, 1, 4'd4,  16'h0010);
        add(0, 16'h0010, 1, 1, 4'd4,  16'h0010);
        add(0, 16'h0010, 1, 1, 4'd4,  16'h0010);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            check($sformatf("vec%0d_valid", i), 32'(Valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_regid", i), 32'(RegId), 32'(tbl[i].er));
            check($sformatf("vec%0d_grant", i), 32'(Grant), 32'(tbl[i].eg));
        end

        drive(1'b1, 16'h0000, 1'b0);
        model_step(1'b1, 16'h0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rreq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) rreq = 16'h0000;
            rrdy = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            drive(rrst, rreq, rrdy);
            model_step(rrst, rreq, rrdy);
            check("rnd_valid", 32'(Valid), 32'(m_valid));
            check("rnd_regid", 32'(RegId), 32'(m_regid));
            check("rnd_grant", 32'(Grant), m_valid ? (32'd1 << m_regid) : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
